// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side bus bundle for the simulink2ppc register.
// Groups master-driven request signals and slave-driven response signals.
interface opb_register_simulink2ppc_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus,
        output OPB_BE,
        output OPB_DBus,
        output OPB_RNW,
        output OPB_select,
        output OPB_seqAddr,
        input  Sl_DBus,
        input  Sl_xferAck,
        input  Sl_errAck,
        input  Sl_retry,
        input  Sl_toutSup
    );

    modport slave (
        input  OPB_ABus,
        input  OPB_BE,
        input  OPB_DBus,
        input  OPB_RNW,
        input  OPB_select,
        input  OPB_seqAddr,
        output Sl_DBus,
        output Sl_xferAck,
        output Sl_errAck,
        output Sl_retry,
        output Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave publishing a fabric value to the PowerPC.
// Exposes DATA, COUNT and STATUS (fresh/overrun) in one address window.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100E500,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100E5FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    opb_register_simulink2ppc_if.slave  opb,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_data_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } state_t;

    // Family string only selects tooling; it has no functional effect.
    if (C_FAMILY == "") begin : g_nofamily
    end

    state_t                    state_q, state_d;
    logic [C_OPB_DWIDTH-1:0]   rdata_q, rdata_d;
    logic [5:0]                off_q, off_d;
    logic                      rnw_q, rnw_d;
    logic                      be_any_q, be_any_d;
    logic [31:0]               data_q, data_d;
    logic [31:0]               count_q, count_d;
    logic                      fresh_q, fresh_d;
    logic                      ovr_q, ovr_d;

    logic [C_OPB_AWIDTH-1:0]   addr;
    logic [5:0]                off;
    logic                      hit;
    logic [C_OPB_DWIDTH-1:0]   rd_mux;
    logic                      ack_cyc;
    logic                      do_wr;
    logic                      rd_data_clr;
    logic                      unused_ok;

    assign addr = opb.OPB_ABus;
    assign off  = opb.OPB_ABus[24:29];
    assign hit  = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    // Write data is never stored: only byte-enable presence matters.
    assign unused_ok = &{1'b0, opb.OPB_seqAddr, opb.OPB_DBus};

    // Read mux over current register contents.
    always_comb begin
        rd_mux = '0;
        unique case (off)
            6'd0:    rd_mux = data_q;
            6'd1:    rd_mux = count_q;
            6'd2:    rd_mux = {30'd0, ovr_q, fresh_q};
            default: rd_mux = '0;
        endcase
    end

    // FSM next state; latch transaction info when the ack is committed.
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        off_d    = off_q;
        rnw_d    = rnw_q;
        be_any_d = be_any_q;
        unique case (state_q)
            S_IDLE: begin
                if (opb.OPB_select && hit) begin
                    state_d  = S_ACK;
                    off_d    = off;
                    rnw_d    = opb.OPB_RNW;
                    be_any_d = |opb.OPB_BE;
                    rdata_d  = opb.OPB_RNW ? rd_mux : '0;
                end
            end
            S_ACK: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!opb.OPB_select) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and transaction registers.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q  <= S_IDLE;
            rdata_q  <= '0;
            off_q    <= '0;
            rnw_q    <= 1'b0;
            be_any_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            off_q    <= off_d;
            rnw_q    <= rnw_d;
            be_any_q <= be_any_d;
        end
    end

    // Bus side effects take place on the edge that ends the ack cycle.
    assign ack_cyc     = (state_q == S_ACK);
    assign do_wr       = ack_cyc && !rnw_q && be_any_q;
    assign rd_data_clr = ack_cyc && rnw_q && (off_q == 6'd0);

    // User-side registers; a capture wins over a concurrent clear.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        fresh_d = fresh_q;
        ovr_d   = ovr_q;
        if (do_wr && off_q == 6'd1) begin
            count_d = '0;
        end
        if (do_wr && off_q == 6'd2) begin
            ovr_d = 1'b0;
        end
        if (rd_data_clr) begin
            fresh_d = 1'b0;
        end
        if (user_data_valid) begin
            data_d  = user_data_in;
            count_d = count_d + 32'd1;
            fresh_d = 1'b1;
            if (fresh_q) begin
                ovr_d = 1'b1;
            end
        end
    end

    // User-side register state.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            data_q  <= '0;
            count_q <= '0;
            fresh_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            fresh_q <= fresh_d;
            ovr_q   <= ovr_d;
        end
    end

    assign opb.Sl_xferAck = ack_cyc;
    assign opb.Sl_DBus    = ack_cyc ? rdata_q : '0;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Scoreboard bench for opb_register_simulink2ppc.
// Stimulus pushes expected ack data; a monitor pops and compares.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE = 32'h0100E500;

    logic        clk;
    logic        rst;
    logic [31:0] udata;
    logic        uvalid;
    int          checks;
    int          errors;
    int          ack_cnt;
    logic [31:0] expq[$];

    opb_register_simulink2ppc_if bus();

    opb_register_simulink2ppc dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .opb             (bus.slave),
        .user_data_in    (udata),
        .user_data_valid (uvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every ack pops one expectation; idle bus must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup} !== 3'b000) begin
                errors++;
                $display("FAIL const_outs: got %b want 000",
                         {bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup});
            end
            if (bus.Sl_xferAck === 1'b1) begin
                ack_cnt++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got data %h want none",
                             bus.Sl_DBus);
                end else begin
                    chk("ack_data", bus.Sl_DBus, expq.pop_front());
                end
            end else begin
                chk("idle_dbus", bus.Sl_DBus, 32'h0);
            end
        end
    end

    task automatic pulse(input logic [31:0] v);
        @(negedge clk);
        udata  = v;
        uvalid = 1'b1;
        @(negedge clk);
        uvalid = 1'b0;
    endtask

    // One transaction; optional valid pulse during the ack cycle.
    task automatic xfer(input logic [31:0] addr, input logic rnw,
                        input logic [3:0] be, input logic [31:0] exp,
                        input bit vin_ack, input logic [31:0] vdata);
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = 32'hDEAD_BEEF;
        bus.OPB_select = 1'b1;
        expq.push_back(rnw ? exp : 32'h0);
        @(negedge clk);
        chk("ack_latency", {31'd0, bus.Sl_xferAck}, 32'd1);
        if (vin_ack) begin
            udata  = vdata;
            uvalid = 1'b1;
        end
        @(negedge clk);
        uvalid         = 1'b0;
        bus.OPB_select = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] o, input logic [31:0] exp);
        xfer(BASE + {24'd0, o}, 1'b1, 4'hF, exp, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [7:0] o, input logic [3:0] be);
        xfer(BASE + {24'd0, o}, 1'b0, be, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic miss(input logic [31:0] addr);
        int a0;
        @(negedge clk);
        a0             = ack_cnt;
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        repeat (8) @(negedge clk);
        bus.OPB_select = 1'b0;
        @(negedge clk);
        #1;
        chk("miss_no_ack", ack_cnt - a0, 32'd0);
    endtask

    initial begin
        int a0;
        checks         = 0;
        errors         = 0;
        ack_cnt        = 0;
        rst            = 1'b1;
        udata          = '0;
        uvalid         = 1'b0;
        bus.OPB_ABus   = '0;
        bus.OPB_BE     = '0;
        bus.OPB_DBus   = '0;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        #1;
        chk("reset_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        chk("reset_dbus", bus.Sl_DBus, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rd(8'h00, 32'h0);
        rd(8'h04, 32'h0);
        rd(8'h08, 32'h0);

        pulse(32'h12345678);
        rd(8'h00, 32'h12345678);
        rd(8'h08, 32'h0);
        rd(8'h04, 32'h1);

        pulse(32'hA);
        pulse(32'hB);
        rd(8'h08, 32'h3);
        wr(8'h08, 4'hF);
        rd(8'h08, 32'h1);
        rd(8'h00, 32'hB);
        rd(8'h08, 32'h0);

        wr(8'h04, 4'h0);
        rd(8'h04, 32'h3);
        wr(8'h00, 4'hF);
        rd(8'h00, 32'hB);
        xfer(BASE + 32'h4, 1'b0, 4'h1, 32'h0, 1'b1, 32'hC);
        rd(8'h04, 32'h1);
        rd(8'h0C, 32'h0);
        rd(8'hFC, 32'h0);
        xfer(BASE, 1'b1, 4'hF, 32'hC, 1'b1, 32'hD);
        rd(8'h08, 32'h3);
        rd(8'h00, 32'hD);
        rd(8'h08, 32'h2);
        rd(8'h04, 32'h2);

        @(negedge clk);
        a0             = ack_cnt;
        bus.OPB_ABus   = BASE + 32'h4;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_BE     = 4'hF;
        bus.OPB_select = 1'b1;
        expq.push_back(32'h2);
        repeat (5) @(negedge clk);
        bus.OPB_select = 1'b0;
        @(negedge clk);
        #1;
        chk("single_ack", ack_cnt - a0, 32'd1);

        miss(32'h0100E600);
        miss(32'h0100E4FC);

        pulse(32'h55);
        @(negedge clk);
        bus.OPB_ABus   = BASE;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        chk("rst_dbus", bus.Sl_DBus, 32'd0);
        bus.OPB_select = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(8'h00, 32'h0);
        rd(8'h04, 32'h0);
        rd(8'h08, 32'h0);

        repeat (2) @(negedge clk);
        chk("queue_drained", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
